// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with parallel load (A-F nibbles saturate to 9) and enable.
// Latency: count/borrow registered, one posedge after inputs are sampled; zero is combinational from count.
// Backpressure: none; borrow is a one-cycle pulse meant to drive en of the next-higher instance.
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow
);

  logic [DIGITS-1:0]   dec_chain;
  logic [4*DIGITS-1:0] load_sat;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] count_nxt;
  logic                borrow_nxt;

  assign dec_chain[0] = 1'b1;

  // A digit steps only when every lower digit is zero; 0 and non-BCD both go to 9.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] digit;
    logic [3:0] load_nib;

    assign digit    = count[4*k +: 4];
    assign load_nib = load_val[4*k +: 4];

    assign load_sat[4*k +: 4] = (load_nib > 4'd9) ? 4'd9 : load_nib;

    assign dec_val[4*k +: 4] = !dec_chain[k]                  ? digit :
                               ((digit == 4'd0) || (digit > 4'd9)) ? 4'd9 :
                               (digit - 4'd1);

    if (k < DIGITS - 1) begin : g_chain
      assign dec_chain[k+1] = dec_chain[k] & (digit == 4'd0);
    end
  end

  assign zero = (count == '0);

  always_comb begin
    count_nxt  = count;
    borrow_nxt = 1'b0;
    if (load) begin
      count_nxt = load_sat;
    end else if (en) begin
      if (zero) begin
        borrow_nxt = 1'b1;
        count_nxt  = (WRAP == 1'b1) ? dec_val : '0;
      end else begin
        count_nxt = dec_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      count  <= count_nxt;
      borrow <= borrow_nxt;
    end
  end

endmodule
